// File: rtl/alarm_ctrl_pkg.sv
// alarm_ctrl_pkg: shared types and constants for the alarm stage.
//   state_t     - alarm FSM states
//   MODE_*      - set_mode output encodings seen by the display stage
//   HOUR_MAX / MIN_MAX - packed-BCD wrap limits for the alarm fields
package alarm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET_H,
    ST_SET_M,
    ST_RING,
    ST_SNOOZE
  } state_t;

  localparam logic [1:0] MODE_NORMAL = 2'd0;
  localparam logic [1:0] MODE_SET_H  = 2'd1;
  localparam logic [1:0] MODE_SET_M  = 2'd2;

  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;

endpackage

// File: rtl/alarm_ctrl_bcd_inc_wrap.sv
// bcd_inc_wrap: combinational packed-BCD increment with wrap to 00.
//   val  in  8  current value, packed BCD ([7:4] tens, [3:0] ones)
//   max  in  8  largest legal value; val==max wraps to 8'h00
//   nxt  out 8  val + 1 in BCD, or 00 after max
module bcd_inc_wrap (
  input  logic [7:0] val,
  input  logic [7:0] max,
  output logic [7:0] nxt
);

  always_comb begin
    nxt = 8'h00;
    if (val == max)
      nxt = 8'h00;
    else if (val[3:0] == 4'd9)
      nxt = {val[7:4] + 4'd1, 4'd0};   // ones roll over into tens
    else
      nxt = {val[7:4], val[3:0] + 4'd1};
  end

endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm stage downstream of the BCD time-of-day counters.
// Holds the alarm time, runs a button-driven set mode, rings a gated
// buzzer with auto-timeout and supports snooze.
//   clk, reset       - clock, synchronous active-high reset
//   tick_1s          - one-clk pulse per second
//   bcd_s/m/h [9:0]  - current time, packed BCD in [7:0], [9:8] zero
//   alarm_en         - level, alarm armed when high
//   btn_set/inc/stop - one-clk debounced button pulses
//   alarm_h/m [7:0]  - alarm time, packed BCD
//   set_mode  [1:0]  - 0 normal, 1 setting hour, 2 setting minute
//   ringing          - high while in RING
//   buzzer           - gated tone enable, 1 s on / 1 s off while ringing
module alarm_ctrl
  import alarm_ctrl_pkg::*;
#(
  parameter logic [7:0] ALARM_H_INIT = 8'h07,
  parameter logic [7:0] ALARM_M_INIT = 8'h00,
  parameter int         RING_SEC     = 60,
  parameter int         SNOOZE_SEC   = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1s,
  input  logic [9:0] bcd_s,
  input  logic [9:0] bcd_m,
  input  logic [9:0] bcd_h,
  input  logic       alarm_en,
  input  logic       btn_set,
  input  logic       btn_inc,
  input  logic       btn_stop,
  output logic [7:0] alarm_h,
  output logic [7:0] alarm_m,
  output logic [1:0] set_mode,
  output logic       ringing,
  output logic       buzzer
);

  localparam logic [7:0] RING_LAST   = 8'(RING_SEC - 1);
  localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_SEC);

  state_t     state;
  logic [7:0] ring_cnt;
  logic [9:0] snooze_cnt;
  logic       match, match_d, trigger;
  logic [7:0] h_next, m_next;

  // Upper BCD bits are always zero by construction of the counters.
  logic unused_hi;
  assign unused_hi = &{1'b0, bcd_s[9:8], bcd_m[9:8], bcd_h[9:8]};

  // Rising edge of match only: one trigger per alarm minute, and editing
  // the alarm to the current time mid-minute never fires (seconds != 00).
  assign match   = (bcd_h[7:0] == alarm_h) && (bcd_m[7:0] == alarm_m) &&
                   (bcd_s[7:0] == 8'h00);
  assign trigger = match && !match_d && alarm_en;

  bcd_inc_wrap u_inc_h (.val(alarm_h), .max(HOUR_MAX), .nxt(h_next));
  bcd_inc_wrap u_inc_m (.val(alarm_m), .max(MIN_MAX),  .nxt(m_next));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      alarm_h    <= ALARM_H_INIT;
      alarm_m    <= ALARM_M_INIT;
      set_mode   <= MODE_NORMAL;
      ringing    <= 1'b0;
      buzzer     <= 1'b0;
      ring_cnt   <= 8'd0;
      snooze_cnt <= 10'd0;
      match_d    <= 1'b0;
    end else begin
      match_d <= match;
      case (state)
        ST_IDLE: begin
          if (!btn_stop && btn_set) begin
            state    <= ST_SET_H;
            set_mode <= MODE_SET_H;
          end else if (trigger) begin
            state    <= ST_RING;
            ring_cnt <= 8'd0;
            ringing  <= 1'b1;
            buzzer   <= 1'b1;
          end
        end

        ST_SET_H: begin
          if (btn_stop) begin
            state    <= ST_IDLE;
            set_mode <= MODE_NORMAL;
          end else if (btn_set) begin
            state    <= ST_SET_M;
            set_mode <= MODE_SET_M;
          end else if (btn_inc) begin
            alarm_h <= h_next;
          end
        end

        ST_SET_M: begin
          if (btn_stop || btn_set) begin
            state    <= ST_IDLE;
            set_mode <= MODE_NORMAL;
          end else if (btn_inc) begin
            alarm_m <= m_next;
          end
        end

        ST_RING: begin
          if (btn_stop || !alarm_en) begin
            state   <= ST_IDLE;
            ringing <= 1'b0;
            buzzer  <= 1'b0;
          end else if (!btn_set && btn_inc) begin
            // btn_set outranks btn_inc but has no action while ringing
            state      <= ST_SNOOZE;
            snooze_cnt <= SNOOZE_LOAD;
            ringing    <= 1'b0;
            buzzer     <= 1'b0;
          end else if (tick_1s) begin
            if (ring_cnt == RING_LAST) begin
              state   <= ST_IDLE;
              ringing <= 1'b0;
              buzzer  <= 1'b0;
            end else begin
              ring_cnt <= ring_cnt + 8'd1;
              buzzer   <= ~buzzer;   // buzzer register doubles as tone phase
            end
          end
        end

        ST_SNOOZE: begin
          if (btn_stop || !alarm_en) begin
            state <= ST_IDLE;
          end else if (tick_1s) begin
            if (snooze_cnt == 10'd1) begin
              state    <= ST_RING;
              ring_cnt <= 8'd0;
              ringing  <= 1'b1;
              buzzer   <= 1'b1;
            end else begin
              snooze_cnt <= snooze_cnt - 10'd1;
            end
          end
        end

        default: begin
          state    <= ST_IDLE;
          set_mode <= MODE_NORMAL;
          ringing  <= 1'b0;
          buzzer   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl. Expected output vectors come from a small
// model (alarm time tracked by the bench) and go through a scoreboard queue.
module tb_alarm_ctrl;

  logic       clk = 1'b0;
  logic       reset, tick_1s, alarm_en, btn_set, btn_inc, btn_stop;
  logic [9:0] bcd_s, bcd_m, bcd_h;
  logic [7:0] alarm_h, alarm_m;
  logic [1:0] set_mode;
  logic       ringing, buzzer;

  alarm_ctrl #(
    .ALARM_H_INIT(8'h07), .ALARM_M_INIT(8'h00),
    .RING_SEC(4), .SNOOZE_SEC(3)
  ) dut (
    .clk(clk), .reset(reset), .tick_1s(tick_1s),
    .bcd_s(bcd_s), .bcd_m(bcd_m), .bcd_h(bcd_h),
    .alarm_en(alarm_en), .btn_set(btn_set), .btn_inc(btn_inc),
    .btn_stop(btn_stop), .alarm_h(alarm_h), .alarm_m(alarm_m),
    .set_mode(set_mode), .ringing(ringing), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [19:0] exp;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_h = 8'h07;
  logic [7:0] exp_m = 8'h00;

  function automatic logic [7:0] bcd_add1(input logic [7:0] v, input int maxd);
    int d;
    d = int'(v[7:4]) * 10 + int'(v[3:0]);
    d = (d == maxd) ? 0 : d + 1;
    return {4'(d / 10), 4'(d % 10)};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input string tag, input logic [1:0] mode,
                      input logic r, input logic b);
    exp_t e;
    e.tag = tag;
    e.exp = {exp_h, exp_m, mode, r, b};
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t        e;
    logic [19:0] obs;
    obs = {alarm_h, alarm_m, set_mode, ringing, buzzer};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: got %h required an entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: got h=%h m=%h mode=%0d ring=%b buz=%b required h=%h m=%h mode=%0d ring=%b buz=%b",
               e.tag, obs[19:12], obs[11:4], obs[3:2], obs[1], obs[0],
               e.exp[19:12], e.exp[11:4], e.exp[3:2], e.exp[1], e.exp[0]);
      end
    end
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m,
                          input logic [7:0] s);
    bcd_h = {2'b00, h};
    bcd_m = {2'b00, m};
    bcd_s = {2'b00, s};
  endtask

  task automatic tick();
    tick_1s = 1'b1;
    cyc(1);
    tick_1s = 1'b0;
  endtask

  task automatic press(input logic s, input logic i, input logic p);
    btn_set = s; btn_inc = i; btn_stop = p;
    cyc(1);
    btn_set = 1'b0; btn_inc = 1'b0; btn_stop = 1'b0;
  endtask

  // Bring time to hh:mm:00 from one second earlier so match rises.
  task automatic fire(input logic [7:0] prev_h, input logic [7:0] prev_m,
                      input logic [7:0] h, input logic [7:0] m);
    set_time(prev_h, prev_m, 8'h59);
    cyc(2);
    set_time(h, m, 8'h00);
    tick();
  endtask

  initial begin
    reset = 1'b1; tick_1s = 1'b0; alarm_en = 1'b0;
    btn_set = 1'b0; btn_inc = 1'b0; btn_stop = 1'b0;
    set_time(8'h00, 8'h00, 8'h00);

    // reset
    cyc(2);
    push("reset", 2'd0, 1'b0, 1'b0); check_pop();
    reset = 1'b0;

    // set mode: hour 07 -> 23 -> 00, minute 00 -> 59 -> 00 -> 01
    press(1, 0, 0);
    push("enter_set_h", 2'd1, 0, 0); check_pop();
    for (int i = 0; i < 16; i++) begin
      press(0, 1, 0);
      exp_h = bcd_add1(exp_h, 23);
    end
    push("hour_23", 2'd1, 0, 0); check_pop();
    press(0, 1, 0);
    exp_h = bcd_add1(exp_h, 23);
    push("hour_wrap", 2'd1, 0, 0); check_pop();
    press(1, 0, 0);
    push("enter_set_m", 2'd2, 0, 0); check_pop();
    for (int i = 0; i < 59; i++) begin
      press(0, 1, 0);
      exp_m = bcd_add1(exp_m, 59);
    end
    push("min_59", 2'd2, 0, 0); check_pop();
    press(0, 1, 0);
    exp_m = bcd_add1(exp_m, 59);
    push("min_wrap", 2'd2, 0, 0); check_pop();
    press(0, 1, 0);
    exp_m = bcd_add1(exp_m, 59);
    push("min_01", 2'd2, 0, 0); check_pop();
    press(1, 0, 0);
    push("exit_set", 2'd0, 0, 0); check_pop();

    // reload 07:00 via reset
    reset = 1'b1; cyc(2); reset = 1'b0;
    exp_h = 8'h07; exp_m = 8'h00;
    push("reset_reload", 2'd0, 0, 0); check_pop();

    // trigger and ring for 4 ticks
    alarm_en = 1'b1;
    set_time(8'h06, 8'h59, 8'h59);
    cyc(3);
    push("pre_match_idle", 2'd0, 0, 0); check_pop();
    set_time(8'h07, 8'h00, 8'h00);
    tick();
    push("ring_start", 2'd0, 1, 1); check_pop();
    cyc(3);
    push("ring_hold", 2'd0, 1, 1); check_pop();
    tick(); push("ring_t1", 2'd0, 1, 0); check_pop();
    tick(); push("ring_t2", 2'd0, 1, 1); check_pop();
    tick(); push("ring_t3", 2'd0, 1, 0); check_pop();
    tick(); push("ring_timeout", 2'd0, 0, 0); check_pop();
    cyc(20);
    push("no_retrigger_after_timeout", 2'd0, 0, 0); check_pop();

    // snooze: 3 ticks quiet, then ring again
    fire(8'h06, 8'h59, 8'h07, 8'h00);
    push("ring_again", 2'd0, 1, 1); check_pop();
    press(0, 1, 0);
    push("snooze_enter", 2'd0, 0, 0); check_pop();
    tick(); push("snooze_t1", 2'd0, 0, 0); check_pop();
    tick(); push("snooze_t2", 2'd0, 0, 0); check_pop();
    tick(); push("snooze_expire", 2'd0, 1, 1); check_pop();
    press(0, 0, 1);
    push("stop_after_snooze", 2'd0, 0, 0); check_pop();
    cyc(30);
    push("hold_match_no_retrigger", 2'd0, 0, 0); check_pop();

    // stop outranks inc in RING
    fire(8'h06, 8'h59, 8'h07, 8'h00);
    push("ring_prio", 2'd0, 1, 1); check_pop();
    press(0, 1, 1);
    push("stop_beats_inc", 2'd0, 0, 0); check_pop();
    tick(); tick(); tick();
    push("stop_not_snoozed", 2'd0, 0, 0); check_pop();

    // alarm_en drop during SNOOZE
    fire(8'h06, 8'h59, 8'h07, 8'h00);
    push("ring_disarm", 2'd0, 1, 1); check_pop();
    press(0, 1, 0);
    alarm_en = 1'b0; cyc(1); alarm_en = 1'b1;
    tick(); tick(); tick();
    push("disarm_in_snooze", 2'd0, 0, 0); check_pop();

    // disarmed at match: no ring, rearm afterwards: still none
    alarm_en = 1'b0;
    fire(8'h06, 8'h59, 8'h07, 8'h00);
    cyc(5);
    push("disarmed_match", 2'd0, 0, 0); check_pop();
    alarm_en = 1'b1;
    cyc(5);
    push("rearm_after_match", 2'd0, 0, 0); check_pop();

    // reset mid-ring with a non-default alarm time
    press(1, 0, 0);
    press(0, 1, 0); exp_h = bcd_add1(exp_h, 23);
    press(0, 1, 0); exp_h = bcd_add1(exp_h, 23);
    press(1, 0, 0);
    press(1, 0, 0);
    push("alarm_09", 2'd0, 0, 0); check_pop();
    fire(8'h08, 8'h59, 8'h09, 8'h00);
    push("ring_09", 2'd0, 1, 1); check_pop();
    reset = 1'b1; cyc(1); reset = 1'b0;
    exp_h = 8'h07; exp_m = 8'h00;
    push("reset_mid_ring", 2'd0, 0, 0); check_pop();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
